// File: rtl/ucsbece154b_burst_pkg.sv
// Shared types and width helpers for the line-refill burst reader.
//   state_e     : burst controller states
//   word_off_w  : bits needed to index a word within a line
//   byte_off_w  : bits needed to index a byte within a line
//   lat_cnt_w   : width of the memory-latency down-counter
package ucsbece154b_burst_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;

  function automatic int word_off_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int byte_off_w(input int block_words, input int data_width);
    return $clog2(block_words * data_width / 8);
  endfunction

  function automatic int lat_cnt_w(input int read_latency);
    return $clog2(read_latency + 1);
  endfunction

endpackage

// File: rtl/ucsbece154b_wrap_ctr.sv
// Modular word-offset counter for a wrapping line burst.
//   load_i  : capture start_i as the first offset, clear the word count
//   en_i    : advance offset (wraps mod BLOCK_WORDS) and word count
//   off_o   : current word offset within the line
//   last_o  : current word is the final word of the burst
module ucsbece154b_wrap_ctr
  import ucsbece154b_burst_pkg::*;
#(
  parameter int BLOCK_WORDS = 4,
  parameter int OW          = word_off_w(BLOCK_WORDS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [OW-1:0] start_i,
  input  logic          en_i,
  output logic [OW-1:0] off_o,
  output logic          last_o
);

  logic [OW-1:0] off_q;
  logic [OW-1:0] cnt_q;

  // OW-bit arithmetic gives the wrap within the line for free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      off_q <= start_i;
      cnt_q <= '0;
    end else if (en_i) begin
      off_q <= off_q + OW'(1);
      cnt_q <= cnt_q + OW'(1);
    end
  end

  assign off_o  = off_q;
  assign last_o = (cnt_q == OW'(BLOCK_WORDS - 1));

endmodule

// File: rtl/ucsbece154b_burst_reader.sv
// Line-refill burst generator feeding the response FIFO.
// Accepts one line request, waits READ_LATENCY cycles, then streams
// BLOCK_WORDS words from a combinational memory port into the FIFO.
// Build option: UCSBECE154B_CRITICAL_WORD_FIRST_EN starts the burst at the
// requested word and wraps within the line; otherwise bursts start at word 0.
// Ports:
//   clk_i, rst_ni            : clock, async active-low reset
//   req_valid_i/addr_i/ready_o : line request handshake
//   abort_i                  : cancel the burst in progress (WAIT/BURST)
//   mem_addr_o, mem_rdata_i  : combinational backing-memory read port
//   fifo_data_o/push_o/full_i: FIFO write side
//   busy_o, done_o           : status; done_o pulses after the last push
module ucsbece154b_burst_reader
  import ucsbece154b_burst_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BLOCK_WORDS  = 4,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  output logic                  fifo_push_o,
  input  logic                  fifo_full_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int OW = word_off_w(BLOCK_WORDS);
  localparam int BW = byte_off_w(BLOCK_WORDS, DATA_WIDTH);
  localparam int WB = BW - OW;  // byte-in-word bits
  localparam int LW = lat_cnt_w(READ_LATENCY);
  localparam logic [LW-1:0] LAT_LOAD = (READ_LATENCY >= 2) ? LW'(READ_LATENCY - 2) : '0;

  state_e                 state_q, state_d;
  logic [LW-1:0]          lat_q;
  logic [ADDR_WIDTH-BW-1:0] line_q;
  logic [OW-1:0]          start, off;
  logic                   last, accept, push;
  logic                   unused_addr;

  assign accept      = (state_q == IDLE) && req_valid_i;
  assign unused_addr = ^req_addr_i;

`ifdef UCSBECE154B_CRITICAL_WORD_FIRST_EN
  assign start = req_addr_i[BW-1:WB];
`else
  assign start = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lat_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat_q  <= LAT_LOAD;
        line_q <= req_addr_i[ADDR_WIDTH-1:BW];
      end else if (state_q == WAIT && lat_q != '0) begin
        lat_q <= lat_q - LW'(1);
      end
    end
  end

  // Never push while full, even if the consumer pops this cycle: full is
  // registered in the FIFO, so this keeps the path loop-free.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    push        = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = (READ_LATENCY == 1) ? BURST : WAIT;
      end
      WAIT: begin
        if (abort_i)           state_d = IDLE;
        else if (lat_q == '0)  state_d = BURST;
      end
      BURST: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (!fifo_full_i) begin
          push = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  ucsbece154b_wrap_ctr #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .OW          (OW)
  ) u_wrap (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (accept),
    .start_i (start),
    .en_i    (push),
    .off_o   (off),
    .last_o  (last)
  );

  assign mem_addr_o  = ADDR_WIDTH'({line_q, off}) << WB;
  assign fifo_data_o = mem_rdata_i;
  assign fifo_push_o = push;
  assign busy_o      = (state_q != IDLE);

endmodule
